// File: rtl/cke_sched_if.sv
// Configuration and enable-pulse bundle for the shared
// clock-enable scheduler.
interface cke_sched_if #(
  parameter int N_CH = 4,
  parameter int CW   = 16
);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch;
  logic [CW-1:0]   cfg_period;
  logic            cfg_en;
  logic            sync;
  logic [N_CH-1:0] cke;
  logic [N_CH-1:0] active;

  modport master (
    output cfg_valid, cfg_ch, cfg_period,
    output cfg_en, sync,
    input  cfg_ready, cke, active
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period,
    input  cfg_en, sync,
    output cfg_ready, cke, active
  );
endinterface

// File: rtl/cke_sched.sv
// Multi-channel clock-enable scheduler on one prescaled
// timebase, retuned through a single-slot config handshake.
module cke_sched #(
  parameter int N_CH     = 4,
  parameter int CW       = 16,
  parameter int PRESCALE = 50
) (
  input logic        clk,
  input logic        rst,
  cke_sched_if.slave bus
);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW  = $clog2(PRESCALE);

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } slot_e;

  slot_e           slot_q;
  logic [PW-1:0]   pcnt_q;
  logic [CHW-1:0]  sch_q;
  logic [CW-1:0]   sper_q;
  logic            sen_q;

  logic [CW-1:0]   per_q  [N_CH];
  logic [CW-1:0]   ccnt_q [N_CH];
  logic [N_CH-1:0] en_q;
  logic [N_CH-1:0] cke_q;
  logic [N_CH-1:0] act;

  logic tick;
  logic apply;
  logic hs;

  assign tick  = (pcnt_q == PW'(PRESCALE - 1));
  assign apply = (slot_q == S_FULL) && tick && !bus.sync;
  assign hs    = bus.cfg_valid && bus.cfg_ready;

  assign bus.cfg_ready = (slot_q == S_EMPTY) && !rst;
  assign bus.cke       = cke_q;
  assign bus.active    = act;

  always_comb begin
    act = '0;
    for (int i = 0; i < N_CH; i++) begin
      act[i] = en_q[i] && (per_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= S_EMPTY;
      pcnt_q <= '0;
      sch_q  <= '0;
      sper_q <= '0;
      sen_q  <= 1'b0;
    end else begin
      if (bus.sync || tick) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_q + PW'(1);
      end
      unique case (slot_q)
        S_EMPTY: begin
          if (hs) begin
            slot_q <= S_FULL;
            sch_q  <= bus.cfg_ch;
            sper_q <= bus.cfg_period;
            sen_q  <= bus.cfg_en;
          end
        end
        S_FULL: begin
          if (apply) slot_q <= S_EMPTY;
        end
        default: slot_q <= S_EMPTY;
      endcase
    end
  end

  // Apply beats counting on its channel; sync beats both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= '0;
      cke_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        per_q[i]  <= '0;
        ccnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cke_q[i] <= 1'b0;
        if (bus.sync) begin
          ccnt_q[i] <= '0;
        end else if (apply && int'(sch_q) == i) begin
          per_q[i]  <= sper_q;
          en_q[i]   <= sen_q;
          ccnt_q[i] <= '0;
        end else if (tick && act[i]) begin
          if (ccnt_q[i] == per_q[i] - CW'(1)) begin
            ccnt_q[i] <= '0;
            cke_q[i]  <= 1'b1;
          end else begin
            ccnt_q[i] <= ccnt_q[i] + CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cke_sched.sv
// Randomized and directed bench for cke_sched against a
// tick-arithmetic reference model.
module tb_cke_sched;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int P  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cke_sched_if #(.N_CH(N), .CW(CW)) bus ();

  cke_sched #(
    .N_CH(N), .CW(CW), .PRESCALE(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: ticks at ref_c + n*P; channel i pulses after
  // every per*P cycles counted from its anchor.
  int cyc;
  int ref_c;
  bit pend;
  int s_ch, s_per;
  bit s_en;
  int m_per [N];
  bit m_en  [N];
  int anc   [N];
  bit m_cke [N];
  int pq [N][$];
  int hsq[$];
  int apq[$];

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_tick(input int c);
    return c > ref_c && (c - ref_c) % P == 0;
  endfunction

  function automatic int qat(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  function automatic int first_after(input int i, input int t);
    foreach (pq[i][k]) if (pq[i][k] > t) return pq[i][k];
    return -1;
  endfunction

  task automatic mreset();
    cyc = 0;
    ref_c = -1;
    pend = 0;
    for (int i = 0; i < N; i++) begin
      m_per[i] = 0;
      m_en[i]  = 0;
      anc[i]   = -1;
      m_cke[i] = 0;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) pq[i].delete();
    hsq.delete();
    apq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.sync = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_cke", bus.cke, 0);
      chk("rst_active", bus.active, 0);
      chk("rst_ready", bus.cfg_ready, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    mreset();
  endtask

  // One cycle: sample at negedge+1, drive, advance model.
  task automatic step(input bit v, input int ch, input int per,
                      input bit en, input bit sy);
    logic [N-1:0] ec, ea;
    bit tk, ap, hs;
    bit nxt [N];
    #1;
    for (int i = 0; i < N; i++) begin
      ec[i] = m_cke[i];
      ea[i] = m_en[i] && m_per[i] != 0;
      if (bus.cke[i]) pq[i].push_back(cyc);
    end
    chk("ready", bus.cfg_ready, !pend);
    chk("cke", bus.cke, ec);
    chk("active", bus.active, ea);
    bus.cfg_valid  = v;
    bus.cfg_ch     = 2'(ch);
    bus.cfg_period = CW'(per);
    bus.cfg_en     = en;
    bus.sync       = sy;
    tk = !sy && is_tick(cyc);
    ap = pend && tk;
    hs = v && !pend;
    for (int i = 0; i < N; i++) begin
      nxt[i] = tk && m_en[i] && m_per[i] != 0 &&
               !(ap && s_ch == i) && cyc > anc[i] &&
               (cyc - anc[i]) % (m_per[i] * P) == 0;
    end
    if (sy) begin
      ref_c = cyc;
      for (int i = 0; i < N; i++) anc[i] = cyc;
    end
    if (ap) begin
      if (s_ch < N) begin
        m_per[s_ch] = s_per;
        m_en[s_ch]  = s_en;
        anc[s_ch]   = cyc;
      end
      pend = 0;
      apq.push_back(cyc);
    end
    if (hs) begin
      pend  = 1;
      s_ch  = ch;
      s_per = per;
      s_en  = en;
      hsq.push_back(cyc);
    end
    for (int i = 0; i < N; i++) m_cke[i] = nxt[i];
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int s, t, ok;
    bus.cfg_valid = 0;
    bus.cfg_ch = '0;
    bus.cfg_period = '0;
    bus.cfg_en = 0;
    bus.sync = 0;
    mreset();
    @(negedge clk);
    do_reset();
    #1;
    chk("ready_after_rst", bus.cfg_ready, 1);

    // ch0 period 3
    clr();
    step(1, 0, 3, 1, 0);
    idle(45);
    chk("p3_first", qat(pq[0], 0) - qat(apq, 0), 13);
    chk("p3_gap1", qat(pq[0], 1) - qat(pq[0], 0), 12);
    chk("p3_gap2", qat(pq[0], 2) - qat(pq[0], 1), 12);

    // ch1 period 1 then ch2 period 2, valid held high
    clr();
    step(1, 1, 1, 1, 0);
    for (int k = 0; k < 20 && hsq.size() < 2; k++)
      step(1, 2, 2, 1, 0);
    idle(24);
    chk("b2b_accept", qat(hsq, 1), qat(apq, 0) + 1);
    chk("b2b_applies", apq.size(), 2);
    chk("c1_gap", qat(pq[1], 1) - qat(pq[1], 0), 4);
    chk("c2_gap", qat(pq[2], 1) - qat(pq[2], 0), 8);
    s = cyc;
    step(0, 0, 0, 0, 1);
    idle(30);
    chk("sync_c1", first_after(1, s) - s, 5);
    chk("sync_c2", first_after(2, s) - s, 9);
    t = first_after(2, s + 9);
    ok = 0;
    foreach (pq[1][k]) if (pq[1][k] == t) ok = 1;
    chk("coincide", ok, 1);

    // ch0 period 5, sync mid-count
    clr();
    step(1, 0, 5, 1, 0);
    idle(30);
    s = cyc;
    step(0, 0, 0, 0, 1);
    idle(30);
    chk("midsync", first_after(0, s) - s, 21);

    // disable ch0 with period 0
    clr();
    step(1, 0, 0, 1, 0);
    idle(10);
    t = qat(apq, 0);
    chk("dis_active", bus.active[0], 0);
    chk("dis_pulses", first_after(0, t), -1);

    // reset with slot FULL while a pulse is high
    step(1, 0, 1, 1, 0);
    for (int k = 0; k < 20 && !is_tick(cyc); k++) idle(1);
    idle(1);
    for (int k = 0; k < 20 && !is_tick(cyc); k++) idle(1);
    step(1, 3, 2, 1, 0);
    chk("pre_rst_pend", pend, 1);
    chk("pre_rst_cke", m_cke[0], 1);
    do_reset();
    idle(20);
    chk("post_rst_active", bus.active, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(3) == 0, $urandom_range(N - 1),
           $urandom_range(4), $urandom_range(1),
           $urandom_range(63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
